dom_and_pipe: RTL and testbench

- Parametrised d-th order Domain-Oriented Masking (DOM) AND gadget.
- Computes a masked WIDTH-bit AND of two Boolean-shared operands with N = ORDER+1 shares each.
- Cross-domain terms are reshared with fresh randomness and registered; same-domain terms are registered alongside them.
- Output is a single pipeline stage with valid/ready flow control, for use as the nonlinear building block in masked S-box and datapath pipelines.

---
 rtl/dom_and_pipe.sv | 97 +++++++++
 tb/tb_dom_and_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dom_and_pipe.sv
// rtl/dom_and_pipe.sv - d-th order DOM AND gadget, one registered stage with valid/ready.
// Optional DOM_AND_PIPE_IDLE_CLEAR_EN: clear term registers on idle consume and gate q_o by valid_o.
module dom_and_pipe #(
    parameter int WIDTH = 8,
    parameter int ORDER = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [(ORDER+1)*WIDTH-1:0]         x_i,
    input  logic [(ORDER+1)*WIDTH-1:0]         y_i,
    input  logic [((ORDER+1)*ORDER/2)*WIDTH-1:0] z_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [(ORDER+1)*WIDTH-1:0]         q_o
);
    localparam int N  = ORDER + 1;
    localparam int NR = N * (N - 1) / 2;

    if ((ORDER < 1) || (ORDER > 4)) begin : g_bad_order
        $error("dom_and_pipe: ORDER must be in 1..4");
    end

    // Row-major index of pair (i,j), i<j: (0,1),(0,2)..(0,N-1),(1,2)..
    function automatic int pair_idx(input int i, input int j);
        return i * N - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    logic                    load;
    logic [N*WIDTH-1:0]      s_d, s_q;
    logic [NR*WIDTH-1:0]     c_lo_d, c_hi_d, c_lo_q, c_hi_q;
    logic [N*WIDTH-1:0]      q_raw;
    logic [WIDTH-1:0]        acc;

    assign ready_o = !valid_o || ready_i;
    assign load    = valid_i && ready_o;
    assign s_d     = x_i & y_i;

    // c_lo holds C_ij (i<j), c_hi holds C_ji; both use the pair's z word.
    always_comb begin
        c_lo_d = '0;
        c_hi_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                c_lo_d[pair_idx(i, j)*WIDTH +: WIDTH] =
                    (x_i[i*WIDTH +: WIDTH] & y_i[j*WIDTH +: WIDTH]) ^ z_i[pair_idx(i, j)*WIDTH +: WIDTH];
                c_hi_d[pair_idx(i, j)*WIDTH +: WIDTH] =
                    (x_i[j*WIDTH +: WIDTH] & y_i[i*WIDTH +: WIDTH]) ^ z_i[pair_idx(i, j)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            s_q     <= '0;
            c_lo_q  <= '0;
            c_hi_q  <= '0;
        end else if (load) begin
            valid_o <= 1'b1;
            s_q     <= s_d;
            c_lo_q  <= c_lo_d;
            c_hi_q  <= c_hi_d;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
`ifdef DOM_AND_PIPE_IDLE_CLEAR_EN
            s_q     <= '0;
            c_lo_q  <= '0;
            c_hi_q  <= '0;
`endif
        end
    end

    // Share compression happens only after the registers.
    always_comb begin
        acc   = '0;
        q_raw = '0;
        for (int i = 0; i < N; i++) begin
            acc = s_q[i*WIDTH +: WIDTH];
            for (int j = 0; j < N; j++) begin
                if (j > i) begin
                    acc = acc ^ c_lo_q[pair_idx(i, j)*WIDTH +: WIDTH];
                end else if (j < i) begin
                    acc = acc ^ c_hi_q[pair_idx(j, i)*WIDTH +: WIDTH];
                end
            end
            q_raw[i*WIDTH +: WIDTH] = acc;
        end
    end

`ifdef DOM_AND_PIPE_IDLE_CLEAR_EN
    assign q_o = valid_o ? q_raw : '0;
`else
    assign q_o = q_raw;
`endif
endmodule

// File: tb/tb_dom_and_pipe.sv
// tb/tb_dom_and_pipe.sv - self-checking bench for dom_and_pipe (ORDER 1 directed, ORDER 1..4 random invariant).
module tb_dom_and_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] xor_red(input logic [39:0] v, input int n);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < n; i++) r = r ^ v[i*8 +: 8];
        return r;
    endfunction

    // Reference for ORDER=1: every unordered pair shares one fresh word between its two cross terms.
    function automatic logic [15:0] model1(input logic [15:0] x, input logic [15:0] y, input logic [7:0] z);
        logic [7:0] xs [2];
        logic [7:0] ys [2];
        logic [7:0] qs [2];
        for (int i = 0; i < 2; i++) begin
            xs[i] = x[i*8 +: 8];
            ys[i] = y[i*8 +: 8];
            qs[i] = xs[i] & ys[i];
        end
        qs[0] = qs[0] ^ (xs[0] & ys[1]) ^ z;
        qs[1] = qs[1] ^ (xs[1] & ys[0]) ^ z;
        return {qs[1], qs[0]};
    endfunction

    logic        m_vi, m_ro, m_vo, m_ri;
    logic [15:0] m_x, m_y, m_q;
    logic [7:0]  m_z;

    dom_and_pipe #(.WIDTH(8), .ORDER(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(m_vi), .ready_o(m_ro),
        .x_i(m_x), .y_i(m_y), .z_i(m_z),
        .valid_o(m_vo), .ready_i(m_ri), .q_o(m_q)
    );

    for (genvar o = 1; o <= 4; o++) begin : g
        localparam int N  = o + 1;
        localparam int NR = N * (N - 1) / 2;
        logic [N*8-1:0]  x, y, q;
        logic [NR*8-1:0] z;
        logic vi, ro, vo, ri;
        logic done;

        dom_and_pipe #(.WIDTH(8), .ORDER(o)) u (
            .clk_i(clk), .rst_ni(rst_n), .valid_i(vi), .ready_o(ro),
            .x_i(x), .y_i(y), .z_i(z),
            .valid_o(vo), .ready_i(ri), .q_o(q)
        );

        initial begin : run
            logic [39:0] fx, fy;
            logic [79:0] fz;
            logic [7:0]  exp_and;
            done = 1'b0;
            vi = 1'b0; ri = 1'b1; x = '0; y = '0; z = '0;
            while (!rst_n) @(posedge clk);
            #1;
            // First operation is the fixed vector (0x12,0x34,0xD9)&(0x0F,0,0); for ORDER=2 the AND is 0x0F.
            fx = 40'h00_00_D9_34_12;
            fy = 40'h00_00_00_00_0F;
            fz = 80'hAA_99_88_77_66_55_44_33_22_11;
            x = fx[N*8-1:0];
            y = fy[N*8-1:0];
            z = fz[NR*8-1:0];
            for (int it = 0; it < 1001; it++) begin
                if (it > 0) begin
                    for (int i = 0; i < N; i++) begin
                        x[i*8 +: 8] = 8'($urandom);
                        y[i*8 +: 8] = 8'($urandom);
                    end
                    for (int k = 0; k < NR; k++) z[k*8 +: 8] = 8'($urandom);
                end
                vi = 1'b1;
                exp_and = xor_red(40'(x), N) & xor_red(40'(y), N);
                @(posedge clk);
                #1;
                chk($sformatf("ord%0d_valid", o), 64'(vo), 64'(1));
                chk($sformatf("ord%0d_xor_it%0d", o, it), 64'(xor_red(40'(q), N)), 64'(exp_and));
            end
            chk($sformatf("ord%0d_ready", o), 64'(ro), 64'(1));
            vi = 1'b0;
            done = 1'b1;
        end
    end

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  z;
        logic [15:0] q;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        vec_t        tbl [6];
        logic [15:0] expq [$];
        logic [15:0] exp_cur;
        logic        occ, occ_next, ld;
        int          cnt;
        bit          all_done;

        tbl[0] = '{16'h3CF0, 16'h0FAA, 8'h5A, 16'h7EFA};
        tbl[1] = '{16'h00FF, 16'h00FF, 8'h00, 16'h00FF};
        tbl[2] = '{16'h00FF, 16'h00FF, 8'hFF, 16'hFF00};
        tbl[3] = '{16'h0000, 16'h0000, 8'hA5, 16'hA5A5};
        for (int r = 4; r < 6; r++) begin
            tbl[r].x = 16'($urandom);
            tbl[r].y = 16'($urandom);
            tbl[r].z = 8'($urandom);
            tbl[r].q = model1(tbl[r].x, tbl[r].y, tbl[r].z);
        end

        m_vi = 1'b0; m_ri = 1'b0; m_x = '0; m_y = '0; m_z = '0;
        #12;
        chk("rst_valid", 64'(m_vo), 64'(0));
        chk("rst_q", 64'(m_q), 64'(0));
        #10 rst_n = 1'b1;
        step();
        chk("rst_ready", 64'(m_ro), 64'(1));

        all_done = 1'b0;
        for (int c = 0; c < 3000 && !all_done; c++) begin
            all_done = g[1].done && g[2].done && g[3].done && g[4].done;
            if (!all_done) @(posedge clk);
        end
        chk("rand_orders_done", 64'(all_done), 64'(1));
        #1;

        // Table: back-to-back loads, result one cycle later.
        for (int r = 0; r < 6; r++) begin
            m_x = tbl[r].x; m_y = tbl[r].y; m_z = tbl[r].z; m_vi = 1'b1; m_ri = 1'b1;
            step();
            chk($sformatf("tbl%0d_valid", r), 64'(m_vo), 64'(1));
            chk($sformatf("tbl%0d_q", r), 64'(m_q), 64'(tbl[r].q));
            chk($sformatf("tbl%0d_xor", r), 64'(m_q[15:8] ^ m_q[7:0]),
                64'((tbl[r].x[15:8] ^ tbl[r].x[7:0]) & (tbl[r].y[15:8] ^ tbl[r].y[7:0])));
        end

        // Backpressure: A held while B waits, then swap in one cycle.
        m_x = tbl[0].x; m_y = tbl[0].y; m_z = tbl[0].z; m_vi = 1'b1; m_ri = 1'b1;
        step();
        chk("bp_a_q", 64'(m_q), 64'(tbl[0].q));
        m_x = tbl[3].x; m_y = tbl[3].y; m_z = tbl[3].z; m_vi = 1'b1; m_ri = 1'b0;
        #1;
        chk("bp_ready_low", 64'(m_ro), 64'(0));
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("bp_hold%0d_valid", c), 64'(m_vo), 64'(1));
            chk($sformatf("bp_hold%0d_ready", c), 64'(m_ro), 64'(0));
            chk($sformatf("bp_hold%0d_q", c), 64'(m_q), 64'(tbl[0].q));
        end
        m_ri = 1'b1;
        #1;
        chk("bp_ready_high", 64'(m_ro), 64'(1));
        step();
        chk("bp_b_valid", 64'(m_vo), 64'(1));
        chk("bp_b_q", 64'(m_q), 64'(tbl[3].q));

        // Consume without a new load.
        m_vi = 1'b0;
        step();
        chk("idle_valid", 64'(m_vo), 64'(0));
        chk("idle_ready", 64'(m_ro), 64'(1));
`ifdef DOM_AND_PIPE_IDLE_CLEAR_EN
        chk("idle_q_cleared", 64'(m_q), 64'(0));
        chk("idle_terms_cleared", 64'({dut.s_q, dut.c_lo_q, dut.c_hi_q}), 64'(0));
`else
        chk("idle_q_held", 64'(m_q), 64'(tbl[3].q));
`endif

        // Streaming 16 operations with ready held high.
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            m_x = 16'($urandom); m_y = 16'($urandom); m_z = 8'($urandom);
            m_vi = 1'b1; m_ri = 1'b1;
            expq.push_back(model1(m_x, m_y, m_z));
            step();
            chk($sformatf("stream%0d_valid", n), 64'(m_vo), 64'(1));
            if (m_vo) cnt++;
            chk($sformatf("stream%0d_q", n), 64'(m_q), 64'(expq.pop_front()));
        end
        chk("stream_count", 64'(cnt), 64'(16));
        m_vi = 1'b0;
        step();

        // Random valid/ready against a one-entry occupancy model.
        occ = 1'b0;
        exp_cur = '0;
        for (int n = 0; n < 300; n++) begin
            m_x = 16'($urandom); m_y = 16'($urandom); m_z = 8'($urandom);
            m_vi = 1'($urandom); m_ri = 1'($urandom);
            #1;
            chk($sformatf("rnd%0d_ready", n), 64'(m_ro), 64'(!occ || m_ri));
            ld = m_vi && (!occ || m_ri);
            occ_next = ld ? 1'b1 : (occ && m_ri ? 1'b0 : occ);
            if (ld) exp_cur = model1(m_x, m_y, m_z);
            step();
            occ = occ_next;
            chk($sformatf("rnd%0d_valid", n), 64'(m_vo), 64'(occ));
            if (occ) chk($sformatf("rnd%0d_q", n), 64'(m_q), 64'(exp_cur));
        end

        // Asynchronous reset while a result is pending.
        m_x = tbl[0].x; m_y = tbl[0].y; m_z = tbl[0].z; m_vi = 1'b1; m_ri = 1'b1;
        step();
        chk("mid_pre_valid", 64'(m_vo), 64'(1));
        m_vi = 1'b0; m_ri = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_vo), 64'(0));
        chk("mid_rst_q", 64'(m_q), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_post_ready", 64'(m_ro), 64'(1));
        chk("mid_post_valid", 64'(m_vo), 64'(0));
        m_x = tbl[2].x; m_y = tbl[2].y; m_z = tbl[2].z; m_vi = 1'b1; m_ri = 1'b1;
        step();
        chk("mid_first_valid", 64'(m_vo), 64'(1));
        chk("mid_first_q", 64'(m_q), 64'(tbl[2].q));
        m_vi = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
